sa_psum_collector: RTL and testbench
====================================

# sa_psum_collector

Receive-side companion of the 16x16 output-stationary systolic array. Captures the column-skewed `psum_out` wavefront and re-aligns it into full 16-wide rows. Accumulates the rows across K-tiles in a local accumulator bank and emits finished rows through a 4-entry valid/ready FIFO toward the requant/writeback path. The array cannot be stalled, so the block absorbs back-pressure in the FIFO and flags any loss.

## Interface
Parameters:
- `DATA_W_OUT`, default 32: psum / accumulator width, two's complement.
- `N`, default 16: array columns. The block is verified at 16 only.
- `ACC_DEPTH`, default 16: output rows per tile, which sets the accumulator bank depth.
- `FIFO_DEPTH`, default 4: output FIFO entries, power of 2.

Ports:
- `clk`  in  1: single clock. Everything is on the rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `psum_in[N]`  in  DATA_W_OUT each: connects directly to the array's `psum_out`.
- `psum_valid`  in  1: column 0 of a result row is valid this cycle; column j is valid j cycles later.
- `tile_first`  in  1: sampled with `psum_valid`. The row overwrites the accumulator.
- `tile_last`  in  1: sampled with `psum_valid`. The completed row is emitted to the FIFO.
- `out_data[N]`  out  DATA_W_OUT each: FIFO head row.
- `out_valid`  out  1: FIFO non-empty.
- `out_ready`  in  1: downstream accepts the head row.
- `busy`  out  1: a valid is in the deskew pipe or the FIFO is non-empty.
- `err_overflow`  out  1: sticky; a row was dropped because the FIFO was full.
- `err_clr`  in  1: synchronous clear of `err_overflow`.

## Operation
- Deskew
  - Column j passes through a register chain of length N-1-j. Column 15 has no chain.
  - `psum_valid`, `tile_first` and `tile_last` travel together through an N-1 stage chain.
  - All columns of a row align at the chain outputs in cycle T+15, where T is the `psum_valid` cycle.
  - An alignment register captures the aligned row and flags at the end of T+15, so the aligned row is valid in cycle T+16.
- Row pointer
  - `row_ptr` is a 0..ACC_DEPTH-1 counter.
  - It increments on each aligned valid and wraps from ACC_DEPTH-1 to 0.
  - It resets to 0 and never resets otherwise.
  - The feeder must issue rows of a tile in order, a multiple of ACC_DEPTH per tile.
- Accumulate, in cycle T+16
  - `sum = tile_first ? row : acc[row_ptr] + row`, element-wise.
  - Arithmetic is modulo 2^DATA_W_OUT with no saturation.
  - `acc[row_ptr] <= sum` is written at the end of the cycle.
  - If `tile_first` and `tile_last` are both set (a single-K-tile case), the row is emitted unaltered.
- Emit
  - When the aligned flag `tile_last` is set, `sum` is pushed into the FIFO in the same cycle.
  - If the FIFO is full and no pop occurs in that cycle, the row is dropped, `err_overflow` is set, and `acc` is still written.
  - Push into a full FIFO with a simultaneous pop is legal and loses nothing.
- FIFO
  - `out_valid` is high when count > 0; `out_data` is the head entry.
  - A pop happens on `out_valid & out_ready`.
  - `out_ready` with an empty FIFO has no effect.
- Back-to-back `psum_valid` on consecutive cycles is supported at full rate, one row per cycle.
- `err_clr` clears the flag. If a drop occurs in the same cycle, set wins.

## Timing
- Reset values:
  - `out_valid=0`, `busy=0`, `err_overflow=0`.
  - `out_data` reads 0, FIFO pointers and count are 0, `row_ptr=0`.
  - All deskew valid and flag bits are 0.
  - Accumulator contents are don't-care; the first access of each tile must carry `tile_first`.
- Latency: `psum_valid` in cycle T with `tile_last`, FIFO empty → `out_valid` high in cycle T+17 with that row.
- Throughput is 1 row/cycle in and 1 row/cycle out.
- `busy` rises in T+1 and falls the cycle after the last valid leaves the pipe and the FIFO drains.
- Reset asserted mid-operation discards all in-flight rows and FIFO contents immediately. Outputs return to reset values asynchronously.
- Column data outside its valid cycle (j cycles after `psum_valid`) is ignored.

## Test plan
- Single tile: one row with `tile_first=tile_last=1` and column j = j+100, driven skewed (col j at T+j) → in cycle T+17 `out_valid=1` and `out_data[j]=j+100`.
- K=3 accumulation: 16 rows × 3 tiles, with row r column j = r*16+j on every tile → 16 emitted rows, each element = 3*(r*16+j), in row order 0..15.
- Wrap arithmetic: tile 1 element = 0x7FFFFFFF, tile 2 element = 1 → emitted element 0x80000000.
- Back-pressure: 6 consecutive `tile_last` rows with `out_ready=0` → FIFO holds rows 0..3 and `err_overflow=1`. Then `out_ready=1` yields rows 0..3 in order, after which `out_valid=0`. Finally `err_clr` clears the flag.
- Full plus simultaneous pop: FIFO full, `out_ready=1` in the push cycle → no drop, `err_overflow` stays 0, count stays 4.
- Mid-stream reset: assert `rst_n=0` at T+8 of a row in flight → outputs are 0 immediately. After release with no new input, `out_valid` never rises. The next row with `tile_first=1` is emitted correctly at its own T+17.

Source files
------------

// File: rtl/sa_psum_collector.sv
// ---------------------------------------------------------------------------
// sa_psum_collector
//
// Receive-side companion of the N x N output-stationary systolic array.
// The array delivers each result row as a skewed wavefront: column j arrives
// j cycles after column 0. This block:
//   1. Delays each column so the whole row lines up, then registers it.
//   2. Accumulates aligned rows across K-tiles in a local accumulator bank.
//   3. Pushes finished rows (tile_last) into a small valid/ready FIFO.
// The array cannot be stalled. Back-pressure is absorbed by the FIFO. Any row
// that cannot be stored is dropped and flagged with a sticky error.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   psum_in[N]    skewed column data from the array
//   psum_valid    column 0 of a row is valid this cycle
//   tile_first    with psum_valid: the row overwrites the accumulator
//   tile_last     with psum_valid: the completed row is emitted
//   out_data[N]   FIFO head row
//   out_valid     FIFO non-empty
//   out_ready     downstream accepts the head row
//   busy          a row is in flight in the deskew pipe, or the FIFO holds data
//   err_overflow  sticky: a finished row was dropped on a full FIFO
//   err_clr       synchronous clear of err_overflow (a same-cycle drop wins)
// ---------------------------------------------------------------------------
module sa_psum_collector #(
    parameter int DATA_W_OUT = 32,
    parameter int N          = 16,
    parameter int ACC_DEPTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W_OUT-1:0] psum_in [N],
    input  logic                  psum_valid,
    input  logic                  tile_first,
    input  logic                  tile_last,
    output logic [DATA_W_OUT-1:0] out_data [N],
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  err_overflow,
    input  logic                  err_clr
);

    localparam int PTR_W  = (ACC_DEPTH > 1) ? $clog2(ACC_DEPTH) : 1;
    localparam int FPTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int STAGES = N - 1;

    // Deskew flag chain: valid/first/last travel with column 0.
    logic [STAGES-1:0]     vld_pipe_r;
    logic [STAGES-1:0]     first_pipe_r;
    logic [STAGES-1:0]     last_pipe_r;

    // Column outputs of the deskew chains. They line up in cycle T+N-1.
    logic [DATA_W_OUT-1:0] aligned_s [N];

    // Alignment register. Holds the full row in cycle T+N.
    logic                  align_vld_r;
    logic                  align_first_r;
    logic                  align_last_r;
    logic [DATA_W_OUT-1:0] align_row_r [N];

    // Accumulator bank and row pointer.
    logic [PTR_W-1:0]      row_ptr_r;
    logic [DATA_W_OUT-1:0] acc_r [ACC_DEPTH][N];
    logic [DATA_W_OUT-1:0] sum_s [N];

    // Output FIFO.
    logic [DATA_W_OUT-1:0] fifo_r [FIFO_DEPTH][N];
    logic [FPTR_W-1:0]     wr_ptr_r;
    logic [FPTR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  push_s;
    logic                  pop_s;
    logic                  full_s;
    logic                  accept_s;
    logic                  drop_s;

    // Per-column delay lines. Column j waits N-1-j cycles. The last column
    // arrives already aligned and bypasses the registers.
    for (genvar j = 0; j < N; j++) begin : g_col
        localparam int LEN = N - 1 - j;
        if (LEN == 0) begin : g_pass
            assign aligned_s[j] = psum_in[j];
        end else begin : g_chain
            logic [DATA_W_OUT-1:0] stg_r [LEN];

            // Shift register that removes this column's remaining skew.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < LEN; k++) begin
                        stg_r[k] <= '0;
                    end
                end else begin
                    stg_r[0] <= psum_in[j];
                    for (int k = 1; k < LEN; k++) begin
                        stg_r[k] <= stg_r[k-1];
                    end
                end
            end

            assign aligned_s[j] = stg_r[LEN-1];
        end
    end

    // Flag chain: the row qualifiers follow column 0 through N-1 stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_r   <= '0;
            first_pipe_r <= '0;
            last_pipe_r  <= '0;
        end else begin
            vld_pipe_r[0]   <= psum_valid;
            first_pipe_r[0] <= tile_first;
            last_pipe_r[0]  <= tile_last;
            for (int k = 1; k < STAGES; k++) begin
                vld_pipe_r[k]   <= vld_pipe_r[k-1];
                first_pipe_r[k] <= first_pipe_r[k-1];
                last_pipe_r[k]  <= last_pipe_r[k-1];
            end
        end
    end

    // Alignment register: captures the re-aligned row and its flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            align_vld_r   <= 1'b0;
            align_first_r <= 1'b0;
            align_last_r  <= 1'b0;
            for (int j = 0; j < N; j++) begin
                align_row_r[j] <= '0;
            end
        end else begin
            align_vld_r   <= vld_pipe_r[STAGES-1];
            align_first_r <= first_pipe_r[STAGES-1];
            align_last_r  <= last_pipe_r[STAGES-1];
            for (int j = 0; j < N; j++) begin
                align_row_r[j] <= aligned_s[j];
            end
        end
    end

    // Element-wise sum. The first K-tile overwrites; later tiles add, wrapping.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            if (align_first_r) begin
                sum_s[j] = align_row_r[j];
            end else begin
                sum_s[j] = acc_r[row_ptr_r][j] + align_row_r[j];
            end
        end
    end

    // Accumulator bank write. Contents need no reset because every tile
    // starts with tile_first.
    always_ff @(posedge clk) begin
        if (align_vld_r) begin
            acc_r[row_ptr_r] <= sum_s;
        end
    end

    // Row pointer: advances once per aligned row and wraps at ACC_DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_ptr_r <= '0;
        end else if (align_vld_r) begin
            if (row_ptr_r == PTR_W'(ACC_DEPTH - 1)) begin
                row_ptr_r <= '0;
            end else begin
                row_ptr_r <= row_ptr_r + PTR_W'(1);
            end
        end
    end

    // FIFO control. A push into a full FIFO still succeeds if the head
    // leaves in the same cycle.
    always_comb begin
        out_valid = (count_r != CNT_W'(0));
        push_s    = align_vld_r & align_last_r;
        pop_s     = out_valid & out_ready;
        full_s    = (count_r == CNT_W'(FIFO_DEPTH));
        accept_s  = push_s & (~full_s | pop_s);
        drop_s    = push_s & full_s & ~pop_s;
        busy      = (|vld_pipe_r) | align_vld_r | out_valid;
    end

    // FIFO storage and write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            for (int e = 0; e < FIFO_DEPTH; e++) begin
                for (int j = 0; j < N; j++) begin
                    fifo_r[e][j] <= '0;
                end
            end
        end else if (accept_s) begin
            fifo_r[wr_ptr_r] <= sum_s;
            if (wr_ptr_r == FPTR_W'(FIFO_DEPTH - 1)) begin
                wr_ptr_r <= '0;
            end else begin
                wr_ptr_r <= wr_ptr_r + FPTR_W'(1);
            end
        end
    end

    // FIFO read pointer and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (pop_s) begin
                if (rd_ptr_r == FPTR_W'(FIFO_DEPTH - 1)) begin
                    rd_ptr_r <= '0;
                end else begin
                    rd_ptr_r <= rd_ptr_r + FPTR_W'(1);
                end
            end
            case ({accept_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head row is read straight from the FIFO registers.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            out_data[j] = fifo_r[rd_ptr_r][j];
        end
    end

    // Sticky overflow flag. A drop in the clear cycle keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_overflow <= 1'b0;
        end else if (drop_s) begin
            err_overflow <= 1'b1;
        end else if (err_clr) begin
            err_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sa_psum_collector.sv
module tb_sa_psum_collector;

    localparam int W    = 32;
    localparam int N    = 16;
    localparam int AD   = 16;
    localparam int FD   = 4;
    localparam int MAXC = 4000;
    localparam int LAT  = 16;   // an issued row is accumulated/pushed at T+16

    typedef logic [N-1:0][W-1:0] prow_t;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] psum_in [N];
    logic         psum_valid;
    logic         tile_first;
    logic         tile_last;
    logic [W-1:0] out_data [N];
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         err_overflow;
    logic         err_clr;

    sa_psum_collector #(
        .DATA_W_OUT(W),
        .N(N),
        .ACC_DEPTH(AD),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .psum_in(psum_in),
        .psum_valid(psum_valid),
        .tile_first(tile_first),
        .tile_last(tile_last),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy(busy),
        .err_overflow(err_overflow),
        .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus schedule, indexed by the cycle in which column 0 is issued.
    logic  row_v [MAXC];
    logic  row_f [MAXC];
    logic  row_l [MAXC];
    prow_t row_d [MAXC];
    logic  rdy_a [MAXC];
    logic  clr_a [MAXC];

    // Reference model state.
    prow_t macc [AD];
    int    mptr;
    logic  merr;
    prow_t mfifo [$];

    int t;
    int rst_at;
    int lat_t;
    int n_chk;
    int n_fail;

    task automatic chk_eq(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", tag, act, exp, t);
        end
    endtask

    task automatic drive(input int c);
        psum_valid = row_v[c];
        tile_first = row_f[c];
        tile_last  = row_l[c];
        out_ready  = rdy_a[c];
        err_clr    = clr_a[c];
        for (int j = 0; j < N; j++) begin
            if (c - j >= 0 && row_v[c-j]) psum_in[j] = row_d[c-j][j];
            else                          psum_in[j] = $urandom;
        end
    endtask

    task automatic check_outputs(input int c);
        logic  pipe;
        prow_t hd;
        pipe = 1'b0;
        for (int k = c - LAT; k <= c - 1; k++) begin
            if (k >= 0 && row_v[k]) pipe = 1'b1;
        end
        chk_eq("out_valid", W'(out_valid), W'(mfifo.size() > 0));
        chk_eq("busy", W'(busy), W'(pipe || (mfifo.size() > 0)));
        chk_eq("err_overflow", W'(err_overflow), W'(merr));
        if (mfifo.size() > 0) begin
            hd = mfifo[0];
            for (int j = 0; j < N; j++) begin
                chk_eq($sformatf("out_data[%0d]", j), out_data[j], hd[j]);
            end
        end
        if (c == lat_t) begin
            chk_eq("latency_valid", W'(out_valid), 32'd1);
            chk_eq("latency_col0", out_data[0], 32'd100);
            chk_eq("latency_col15", out_data[N-1], 32'd115);
        end
    endtask

    // Advance the model over the end of cycle c.
    task automatic model_step(input int c);
        logic  pop;
        logic  push;
        logic  drop;
        prow_t s;
        int    tr;
        pop  = (mfifo.size() > 0) && rdy_a[c];
        push = 1'b0;
        s    = '0;
        tr   = c - LAT;
        if (tr >= 0 && row_v[tr]) begin
            for (int j = 0; j < N; j++) begin
                s[j] = row_f[tr] ? row_d[tr][j] : macc[mptr][j] + row_d[tr][j];
            end
            macc[mptr] = s;
            mptr = (mptr + 1) % AD;
            push = row_l[tr];
        end
        drop = push && (mfifo.size() == FD) && !pop;
        if (pop) void'(mfifo.pop_front());
        if (push && !drop) mfifo.push_back(s);
        if (drop) merr = 1'b1;
        else if (clr_a[c]) merr = 1'b0;
    endtask

    task automatic run_to(input int tend);
        while (t < tend) begin
            drive(t);
            @(negedge clk);
            if (t == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk_eq("rst_out_valid", W'(out_valid), 32'd0);
                chk_eq("rst_busy", W'(busy), 32'd0);
                chk_eq("rst_err", W'(err_overflow), 32'd0);
                chk_eq("rst_out_data0", out_data[0], 32'd0);
                mfifo.delete();
                mptr = 0;
                merr = 1'b0;
                for (int k = t - LAT; k <= t; k++) begin
                    if (k >= 0) row_v[k] = 1'b0;
                end
            end else begin
                check_outputs(t);
                model_step(t);
            end
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            t++;
        end
    endtask

    task automatic sched_row(input int c, input logic f, input logic l);
        row_v[c] = 1'b1;
        row_f[c] = f;
        row_l[c] = l;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int c;
        int kt;
        n_chk  = 0;
        n_fail = 0;
        t      = 0;
        rst_at = -1;
        lat_t  = -1;
        mptr   = 0;
        merr   = 1'b0;
        for (int i = 0; i < MAXC; i++) begin
            row_v[i] = 1'b0;
            row_f[i] = 1'b0;
            row_l[i] = 1'b0;
            row_d[i] = '0;
            rdy_a[i] = 1'b1;
            clr_a[i] = 1'b0;
        end
        rst_n      = 1'b0;
        psum_valid = 1'b0;
        tile_first = 1'b0;
        tile_last  = 1'b0;
        out_ready  = 1'b0;
        err_clr    = 1'b0;
        for (int j = 0; j < N; j++) psum_in[j] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("reset_out_valid", W'(out_valid), 32'd0);
        chk_eq("reset_busy", W'(busy), 32'd0);
        chk_eq("reset_err", W'(err_overflow), 32'd0);
        chk_eq("reset_out_data0", out_data[0], 32'd0);
        chk_eq("reset_out_data15", out_data[N-1], 32'd0);
        rst_n = 1'b1;

        // Single-tile row, column j = j+100.
        t0 = t + 2;
        for (int j = 0; j < N; j++) row_d[t0][j] = W'(j + 100);
        sched_row(t0, 1'b1, 1'b1);
        lat_t = t0 + 17;
        run_to(t0 + 25);

        // K=3 accumulation, back-to-back rows.
        t0 = t + 1;
        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < AD; r++) begin
                c = t0 + k * AD + r;
                for (int j = 0; j < N; j++) row_d[c][j] = W'(r * 16 + j);
                sched_row(c, k == 0, k == 2);
            end
        end
        run_to(t0 + 3 * AD + 25);

        // Wrap arithmetic: 0x7FFFFFFF + 1.
        t0 = t + 1;
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < AD; r++) begin
                c = t0 + k * AD + r;
                for (int j = 0; j < N; j++) row_d[c][j] = (k == 0) ? 32'h7FFF_FFFF : 32'h0000_0001;
                sched_row(c, k == 0, k == 1);
            end
        end
        run_to(t0 + 2 * AD + 25);

        // Back-pressure: 6 rows into a stalled FIFO; clear in a drop cycle, then later.
        t0 = t + 1;
        for (int r = 0; r < 6; r++) begin
            for (int j = 0; j < N; j++) row_d[t0 + r][j] = $urandom;
            sched_row(t0 + r, 1'b1, 1'b1);
        end
        for (int i = t0; i <= t0 + 30; i++) rdy_a[i] = 1'b0;
        clr_a[t0 + 21] = 1'b1;
        clr_a[t0 + 40] = 1'b1;
        run_to(t0 + 45);

        // Full FIFO with a pop in the push cycle.
        t0 = t + 1;
        for (int r = 0; r < 5; r++) begin
            c = (r < 4) ? t0 + r : t0 + 10;
            for (int j = 0; j < N; j++) row_d[c][j] = $urandom;
            sched_row(c, 1'b1, 1'b1);
        end
        for (int i = t0; i <= t0 + 35; i++) rdy_a[i] = 1'b0;
        rdy_a[t0 + 26] = 1'b1;
        run_to(t0 + 50);

        // Reset in the middle of a row's flight, then a fresh row.
        t0 = t + 1;
        for (int j = 0; j < N; j++) row_d[t0][j] = $urandom;
        sched_row(t0, 1'b1, 1'b1);
        rst_at = t0 + 8;
        run_to(t0 + 40);
        t0 = t + 1;
        for (int j = 0; j < N; j++) row_d[t0][j] = $urandom;
        sched_row(t0, 1'b1, 1'b1);
        run_to(t0 + 25);

        // Random K-tile groups with gaps and random back-pressure.
        for (int g = 0; g < 3; g++) begin
            kt = $urandom_range(3, 1);
            t0 = t + 1;
            c  = t0;
            for (int k = 0; k < kt; k++) begin
                for (int r = 0; r < AD; r++) begin
                    for (int j = 0; j < N; j++) row_d[c][j] = $urandom;
                    sched_row(c, k == 0, k == kt - 1);
                    c = c + 1 + int'($urandom_range(2, 0));
                end
            end
            for (int i = t0; i <= c + 30; i++) rdy_a[i] = ($urandom_range(3, 0) != 0);
            clr_a[c + 35] = 1'b1;
            run_to(c + 60);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
